// File: rtl/updn_counter_pkg.sv
// updn_counter_pkg: limit-mode constants and parameter legality check for updn_counter_gen
package updn_counter_pkg;
  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;
  function automatic bit params_ok(int width, int min_val, int max_val, int step_w, int reset_val);
    return (width > 0) && (width < 31) && (min_val >= 0) && (min_val < max_val) &&
           (max_val <= (1 << width) - 1) && (step_w > 0) &&
           ((1 << step_w) - 1 <= max_val - min_val + 1) &&
           (reset_val >= min_val) && (reset_val <= max_val);
  endfunction
endpackage

// File: rtl/updn_step_calc.sv
// updn_step_calc: next count for one up/down step with saturate or wrap at the limits
module updn_step_calc
  import updn_counter_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int STEP_W = 3,
  parameter int WRAP   = MODE_SAT
) (
  input  logic [WIDTH-1:0]  i_cnt,
  input  logic [STEP_W-1:0] i_step,
  input  logic              i_down,
  input  logic [WIDTH-1:0]  i_min,
  input  logic [WIDTH-1:0]  i_max,
  output logic [WIDTH-1:0]  o_next,
  output logic              o_ovf,
  output logic              o_unf
);
  localparam int EW = WIDTH + 2;
  // two guard bits keep both the borrow below zero and the carry past MAX visible
  logic signed [EW-1:0] w_cnt, w_step, w_min, w_max, w_rng, w_d, w_u, w_dn, w_up;
  logic w_under, w_over;
  assign w_cnt   = $signed({2'b00, i_cnt});
  assign w_step  = $signed({{(EW-STEP_W){1'b0}}, i_step});
  assign w_min   = $signed({2'b00, i_min});
  assign w_max   = $signed({2'b00, i_max});
  assign w_rng   = w_max - w_min + EW'(1);
  assign w_d     = w_cnt - w_step;
  assign w_u     = w_cnt + w_step;
  assign w_under = w_d < w_min;
  assign w_over  = w_u > w_max;
  assign w_dn    = !w_under ? w_d : (WRAP == MODE_WRAP) ? w_d + w_rng : w_min;
  assign w_up    = !w_over  ? w_u : (WRAP == MODE_WRAP) ? w_u - w_rng : w_max;
  assign o_next  = i_down ? w_dn[WIDTH-1:0] : w_up[WIDTH-1:0];
  assign o_ovf   = !i_down && w_over;
  assign o_unf   = i_down && w_under;
endmodule

// File: rtl/updn_counter_gen.sv
// updn_counter_gen: parametrised load/up/down counter with step, saturate-or-wrap,
// load clamping and registered overflow/underflow/load-error pulses
module updn_counter_gen
  import updn_counter_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int MIN_VAL   = 0,
  parameter int MAX_VAL   = 2**WIDTH - 1,
  parameter int STEP_W    = 3,
  parameter int WRAP      = MODE_SAT,
  parameter int RESET_VAL = MIN_VAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              EN,
  input  logic              LOAD,
  input  logic [WIDTH-1:0]  IN,
  input  logic              Up,
  input  logic              Down,
  input  logic [STEP_W-1:0] STEP,
  output logic [WIDTH-1:0]  Counter,
  output logic              High,
  output logic              Low,
  output logic              OVF,
  output logic              UNF,
  output logic              LOAD_ERR
);
  localparam logic [WIDTH-1:0] L_MIN = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] L_RST = WIDTH'(RESET_VAL);
  if (!params_ok(WIDTH, MIN_VAL, MAX_VAL, STEP_W, RESET_VAL)) begin : g_bad_params
    $error("updn_counter_gen: illegal WIDTH/MIN_VAL/MAX_VAL/STEP_W/RESET_VAL combination");
  end
  logic [WIDTH-1:0] r_cnt, w_next, w_load_val, w_cnt_d;
  logic r_ovf, r_unf, r_lerr, w_ovf, w_unf, w_in_lo, w_in_hi, w_act;
  logic w_ovf_d, w_unf_d, w_lerr_d;
  updn_step_calc #(.WIDTH(WIDTH), .STEP_W(STEP_W), .WRAP(WRAP)) u_step (
    .i_cnt  (r_cnt),
    .i_step (STEP),
    .i_down (Down),
    .i_min  (L_MIN),
    .i_max  (L_MAX),
    .o_next (w_next),
    .o_ovf  (w_ovf),
    .o_unf  (w_unf)
  );
  // signed compares avoid constant-false checks when MIN_VAL is zero
  assign w_in_lo    = $signed({1'b0, IN}) < $signed({1'b0, L_MIN});
  assign w_in_hi    = $signed({1'b0, IN}) > $signed({1'b0, L_MAX});
  assign w_load_val = w_in_lo ? L_MIN : w_in_hi ? L_MAX : IN;
  assign w_act      = EN && (STEP != '0) && (Up || Down);
  always_comb begin
    w_cnt_d  = LOAD ? w_load_val : w_act ? w_next : r_cnt;
    w_ovf_d  = !LOAD && w_act && w_ovf;
    w_unf_d  = !LOAD && w_act && w_unf;
    w_lerr_d = LOAD && (w_in_lo || w_in_hi);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= L_RST;
      r_ovf  <= 1'b0;
      r_unf  <= 1'b0;
      r_lerr <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_d;
      r_ovf  <= w_ovf_d;
      r_unf  <= w_unf_d;
      r_lerr <= w_lerr_d;
    end
  end
  assign Counter  = r_cnt;
  assign High     = r_cnt == L_MAX;
  assign Low      = r_cnt == L_MIN;
  assign OVF      = r_ovf;
  assign UNF      = r_unf;
  assign LOAD_ERR = r_lerr;
endmodule

// File: tb/tb_updn_counter_gen.sv
// tb_updn_counter_gen: scoreboard bench driving three counter configurations with shared stimulus
module tb_updn_counter_gen;
  logic clk = 1'b0;
  logic rst = 1'b0, EN = 1'b0, LOAD = 1'b0, Up = 1'b0, Down = 1'b0;
  logic [4:0] IN = '0;
  logic [2:0] STEP = '0;
  logic [4:0] cnt [3];
  logic hi [3], lo [3], ovf [3], unf [3], lerr [3];
  int total = 0, bad = 0;
  int mmin [3] = '{0, 0, 4};
  int mmax [3] = '{31, 31, 20};
  bit mwrap [3] = '{1'b0, 1'b1, 1'b0};
  int mcnt [3] = '{0, 0, 4};
  typedef struct {
    logic [2:0][4:0] cnt;
    logic [2:0] hi, lo, ovf, unf, lerr;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  updn_counter_gen u0 (
    .clk(clk), .rst(rst), .EN(EN), .LOAD(LOAD), .IN(IN), .Up(Up), .Down(Down), .STEP(STEP),
    .Counter(cnt[0]), .High(hi[0]), .Low(lo[0]), .OVF(ovf[0]), .UNF(unf[0]), .LOAD_ERR(lerr[0])
  );
  updn_counter_gen #(.WRAP(1)) u1 (
    .clk(clk), .rst(rst), .EN(EN), .LOAD(LOAD), .IN(IN), .Up(Up), .Down(Down), .STEP(STEP),
    .Counter(cnt[1]), .High(hi[1]), .Low(lo[1]), .OVF(ovf[1]), .UNF(unf[1]), .LOAD_ERR(lerr[1])
  );
  updn_counter_gen #(.MIN_VAL(4), .MAX_VAL(20)) u2 (
    .clk(clk), .rst(rst), .EN(EN), .LOAD(LOAD), .IN(IN), .Up(Up), .Down(Down), .STEP(STEP),
    .Counter(cnt[2]), .High(hi[2]), .Low(lo[2]), .OVF(ovf[2]), .UNF(unf[2]), .LOAD_ERR(lerr[2])
  );
  task automatic drive(bit r, bit l, int v, bit e, bit u, bit d, int s);
    exp_t x;
    rst = r; LOAD = l; IN = 5'(v); EN = e; Up = u; Down = d; STEP = 3'(s);
    for (int k = 0; k < 3; k++) begin
      int c = mcnt[k];
      int rng = mmax[k] - mmin[k] + 1;
      bit o = 0, un = 0, le = 0;
      if (r) c = mmin[k];
      else if (l) begin
        if (v < mmin[k]) begin c = mmin[k]; le = 1; end
        else if (v > mmax[k]) begin c = mmax[k]; le = 1; end
        else c = v;
      end else if (e && s != 0 && (u || d)) begin
        if (d) begin
          c = c - s;
          if (c < mmin[k]) begin un = 1; c = mwrap[k] ? c + rng : mmin[k]; end
        end else begin
          c = c + s;
          if (c > mmax[k]) begin o = 1; c = mwrap[k] ? c - rng : mmax[k]; end
        end
      end
      mcnt[k] = c;
      x.cnt[k] = 5'(c);
      x.hi[k] = (c == mmax[k]);
      x.lo[k] = (c == mmin[k]);
      x.ovf[k] = o;
      x.unf[k] = un;
      x.lerr[k] = le;
    end
    q.push_back(x);
    @(negedge clk);
  endtask
  always @(posedge clk) begin
    exp_t x;
    #1;
    if (q.size() != 0) begin
      x = q.pop_front();
      for (int k = 0; k < 3; k++) begin
        total++;
        if ({cnt[k], hi[k], lo[k], ovf[k], unf[k], lerr[k]} !==
            {x.cnt[k], x.hi[k], x.lo[k], x.ovf[k], x.unf[k], x.lerr[k]}) begin
          bad++;
          $display("FAIL dut%0d t=%0t: got cnt=%0d hi=%b lo=%b ovf=%b unf=%b lerr=%b, want cnt=%0d hi=%b lo=%b ovf=%b unf=%b lerr=%b",
                   k, $time, cnt[k], hi[k], lo[k], ovf[k], unf[k], lerr[k],
                   x.cnt[k], x.hi[k], x.lo[k], x.ovf[k], x.unf[k], x.lerr[k]);
        end
      end
    end
  end
  initial begin
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 31; i++) drive(0, 0, 0, 1, 1, 0, 1);
    drive(0, 0, 0, 1, 1, 0, 1);
    drive(0, 0, 0, 1, 1, 0, 1);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 30, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 3);
    drive(0, 0, 0, 1, 0, 1, 2);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 25, 0, 0, 0, 0);
    drive(0, 1, 2, 0, 0, 0, 0);
    drive(0, 1, 10, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 1, 2);
    drive(0, 1, 10, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 1, 2);
    drive(0, 1, 7, 0, 1, 1, 2);
    drive(0, 1, 12, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0);
    drive(0, 1, 4, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 1, 7);
    drive(0, 0, 0, 1, 0, 1, 7);
    drive(1, 1, 9, 1, 1, 0, 3);
    for (int i = 0; i < 600; i++)
      drive($urandom_range(49) == 0, $urandom_range(7) == 0, $urandom_range(31),
            $urandom_range(3) != 0, 1'($urandom), 1'($urandom), $urandom_range(7));
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
